// File: rtl/mdu_defs.sv
// Shared definitions for the multiply/divide unit: op encodings and default latencies.
package mdu_defs;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;
  localparam int unsigned DEF_CNT_W       = 4;

  // True for the four ops that occupy the unit for multiple cycles.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 32x32 multiply and divide producing a HI/LO pair plus a div-by-zero flag.
module mdu_arith
  import mdu_defs::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] b_safe;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic [31:0] quot_u;
  logic [31:0] rem_u;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Divisor is forced nonzero so simulation never sees X; the result is discarded anyway.
  assign div_zero = (b == 32'd0);
  assign b_safe   = div_zero ? 32'd1 : b;

  // SV signed division truncates toward zero and the remainder takes the dividend's sign.
  assign quot_s = $signed(a) / $signed(b_safe);
  assign rem_s  = $signed(a) % $signed(b_safe);
  assign quot_u = a / b_safe;
  assign rem_u  = a % b_safe;

  // Select the HI/LO pair for the requested op.
  always_comb begin
    hi = 32'd0;
    lo = 32'd0;
    unique case (op)
      MD_MULT:  {hi, lo} = prod_s;
      MD_MULTU: {hi, lo} = prod_u;
      MD_DIV:   begin hi = rem_s; lo = quot_s; end
      MD_DIVU:  begin hi = rem_u; lo = quot_u; end
      default:  begin hi = 32'd0; lo = 32'd0; end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: fixed-latency sequencing, HI/LO ownership, stall term.
module mdu_ctrl
  import mdu_defs::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        E_start,
  input  logic [2:0]  E_mdop,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_is_md,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        md_stall
);

  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      pend_hi_q;
  logic [31:0]      pend_lo_q;
  logic             pend_dz_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;

  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             res_dz;
  logic             start_op;
  logic             is_div;

  mdu_arith u_arith (
    .a        (E_A),
    .b        (E_B),
    .op       (E_mdop),
    .hi       (res_hi),
    .lo       (res_lo),
    .div_zero (res_dz)
  );

  assign start_op = E_start && is_long_op(E_mdop);
  assign is_div   = (E_mdop == MD_DIV) || (E_mdop == MD_DIVU);

  // Counter is the state: zero is idle, nonzero counts down to the commit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_dz_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else if (cnt_q == '0) begin
      if (start_op) begin
        pend_hi_q <= res_hi;
        pend_lo_q <= res_lo;
        // Only a divide can fault; multiplies by zero are legitimate.
        pend_dz_q <= is_div && res_dz;
        cnt_q     <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (E_mdop == MD_MTHI) begin
        hi_q <= E_A;
      end else if (E_mdop == MD_MTLO) begin
        lo_q <= E_A;
      end
    end else begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1) && !pend_dz_q) begin
        hi_q <= pend_hi_q;
        lo_q <= pend_lo_q;
      end
    end
  end

  assign HI       = hi_q;
  assign LO       = lo_q;
  assign busy     = (cnt_q != '0);
  // E_start term covers the issue cycle, before busy has risen.
  assign md_stall = D_is_md & (busy | E_start);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl.
module tb_mdu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        E_start;
  logic [2:0]  E_mdop;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_is_md;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        md_stall;

  int n_checks = 0;
  int n_pass   = 0;

  mdu_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .E_start  (E_start),
    .E_mdop   (E_mdop),
    .E_A      (E_A),
    .E_B      (E_B),
    .D_is_md  (D_is_md),
    .HI       (HI),
    .LO       (LO),
    .busy     (busy),
    .md_stall (md_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The hazard unit never issues into a busy MDU; flag it if the bench ever does.
  always @(posedge clk) begin
    if (rst_n && busy) begin
      assert (!E_start && E_mdop != 3'd5 && E_mdop != 3'd6)
        else $error("issue while busy");
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance past an active edge; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    E_start = (op >= 3'd1 && op <= 3'd4);
    E_mdop  = op;
    E_A     = a;
    E_B     = b;
    step();
    E_start = 1'b0;
    E_mdop  = 3'd0;
  endtask

  // Count samples with busy high (bounded), then compare to the expected latency.
  task automatic wait_done(input string tag, input int exp_len);
    int n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
    check(tag, 64'(n), 64'(exp_len));
  endtask

  initial begin
    rst_n   = 1'b0;
    E_start = 1'b0;
    E_mdop  = 3'd0;
    E_A     = 32'd0;
    E_B     = 32'd0;
    D_is_md = 1'b0;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi", 64'(HI), 64'd0);
    check("rst_lo", 64'(LO), 64'd0);
    rst_n = 1'b1;
    step();

    // MULT -3 * 5 = -15
    issue(3'd1, 32'hFFFF_FFFD, 32'd5);
    check("mult_busy_rise", 64'(busy), 64'd1);
    wait_done("mult_len", 5);
    check("mult_hi", 64'(HI), 64'hFFFF_FFFF);
    check("mult_lo", 64'(LO), 64'hFFFF_FFF1);

    // DIVU 100 / 7
    issue(3'd4, 32'd100, 32'd7);
    check("divu_hold_lo", 64'(LO), 64'hFFFF_FFF1);
    wait_done("divu_len", 10);
    check("divu_lo", 64'(LO), 64'd14);
    check("divu_hi", 64'(HI), 64'd2);

    // DIV -7 / 2: quotient -3, remainder -1
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_len", 10);
    check("div_lo", 64'(LO), 64'hFFFF_FFFD);
    check("div_hi", 64'(HI), 64'hFFFF_FFFF);

    // Divide by zero leaves preloaded HI/LO intact
    issue(3'd5, 32'h11, 32'd0);
    check("mthi_busy", 64'(busy), 64'd0);
    issue(3'd6, 32'h22, 32'd0);
    check("mthi_hi", 64'(HI), 64'h11);
    check("mtlo_lo", 64'(LO), 64'h22);
    issue(3'd3, 32'd5, 32'd0);
    wait_done("dz_len", 10);
    check("dz_hi", 64'(HI), 64'h11);
    check("dz_lo", 64'(LO), 64'h22);

    // MTLO in idle
    issue(3'd6, 32'hABCD, 32'd0);
    check("mtlo2_lo", 64'(LO), 64'hABCD);
    check("mtlo2_busy", 64'(busy), 64'd0);
    step();
    check("mtlo2_busy_later", 64'(busy), 64'd0);

    // md_stall across a MULT 6*7 with D_is_md held high
    D_is_md = 1'b1;
    check("stall_idle", 64'(md_stall), 64'd0);
    E_start = 1'b1;
    E_mdop  = 3'd1;
    E_A     = 32'd6;
    E_B     = 32'd7;
    #1;
    check("stall_start", 64'(md_stall), 64'd1);
    step();
    E_start = 1'b0;
    E_mdop  = 3'd0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_busy%0d", i), 64'(md_stall), 64'd1);
      step();
    end
    check("stall_end", 64'(md_stall), 64'd0);
    check("stall_mult_lo", 64'(LO), 64'd42);
    check("stall_mult_hi", 64'(HI), 64'd0);
    D_is_md = 1'b0;

    // Reset mid-DIV aborts and discards the pending result
    issue(3'd5, 32'h55, 32'd0);
    issue(3'd4, 32'd50, 32'd3);
    step();
    step();
    check("abort_pre_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(HI), 64'd0);
    check("abort_lo", 64'(LO), 64'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check("abort_late_busy", 64'(busy), 64'd0);
    check("abort_late_hi", 64'(HI), 64'd0);
    check("abort_late_lo", 64'(LO), 64'd0);

    // Back-to-back MULTU then MULT on the first idle cycle
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_len", 5);
    check("multu_hi", 64'(HI), 64'hFFFF_FFFE);
    check("multu_lo", 64'(LO), 64'h0000_0001);
    issue(3'd1, 32'd2, 32'hFFFF_FFFD);
    check("b2b_busy", 64'(busy), 64'd1);
    wait_done("b2b_len", 5);
    check("b2b_hi", 64'(HI), 64'hFFFF_FFFF);
    check("b2b_lo", 64'(LO), 64'hFFFF_FFFA);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide unit controller for the 5-stage MIPS pipeline, sitting in the E stage beside the ALU.
- Accepts MDU instructions (MULT, MULTU, DIV, DIVU, MTHI, MTLO) from E and sequences a fixed-latency operation.
- Owns the HI/LO architectural registers.
- Supplies the busy-based stall term that the hazard unit ORs into its D-stage Stall.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
E_start  in  1  E-stage instruction is MULT/MULTU/DIV/DIVU (0 for bubbles)
E_mdop  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
E_A  in  32  forwarded rs value (post CEA mux)
E_B  in  32  forwarded rt value (post CEB mux)
D_is_md  in  1  D-stage instruction uses MDU (any mult/div/mf/mt)
HI  out  32  HI register
LO  out  32  LO register
busy  out  1  operation in flight
md_stall  out  1  stall request to hazard unit

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: HI=0, LO=0, busy=0, counter=0, pending HI/LO=0. Asserting rst_n mid-operation aborts the operation; the pending result is discarded.
- States: IDLE (cnt==0) and RUN (cnt!=0). busy = (cnt!=0), taken directly from the register.
- IDLE -> RUN, on a rising edge with E_start=1 and E_mdop in 1..4:
  - Compute the result from E_A/E_B and latch it into pending regs.
  - Load cnt = MULT_CYCLES or DIV_CYCLES.
- RUN: cnt decrements every edge. On the edge where cnt==1, HI/LO <= pending and cnt becomes 0 (-> IDLE).
  - Net effect: busy is high for exactly N cycles after the start edge.
  - New HI/LO are visible in the first cycle busy is low.
- Arithmetic:
  - MULT: 64-bit signed product, HI = bits 63:32, LO = bits 31:0.
  - MULTU: same, unsigned.
  - DIV: LO = quotient truncated toward zero, HI = remainder with the dividend's sign.
  - DIVU: unsigned quotient/remainder.
- Divide by zero: cnt is still loaded (busy for DIV_CYCLES); HI/LO are left unchanged at completion.
- MTHI/MTLO in IDLE: HI (or LO) <= E_A at that edge; single cycle; busy stays 0.
- E_start or MTHI/MTLO while busy: ignored. The hazard unit guarantees this cannot happen; the bench asserts it.
- md_stall = D_is_md & (busy | E_start). Combinational; it holds an MF/MT/mult in D until the result is committed.
- No forwarding of pending results. MFHI/MFLO read HI/LO only after busy drops.

Decomposition:
- Shared package (mdu_defs): MDU op encodings (MD_NONE..MD_MTLO) and default cycle counts.
- One sub-module, mdu_arith: combinational 64-bit signed/unsigned multiply and divide, with a div-by-zero flag.
- The controller keeps the counter, pending registers and HI/LO.

Test Plan:
1. MULT E_A=0xFFFFFFFD (-3), E_B=5 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
2. DIVU 100/7 -> busy 10 cycles; then LO=14, HI=2. DIV 0xFFFFFFF9 (-7)/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. DIV by zero with HI=0x11, LO=0x22 preloaded via MTHI/MTLO -> busy 10 cycles; HI/LO remain 0x11/0x22.
4. MTLO E_A=0xABCD in IDLE -> LO=0xABCD next cycle, busy never rises. D_is_md=1 during a MULT -> md_stall=1 on the start cycle plus 5 busy cycles, then 0.
5. Deassert rst_n at cycle 3 of a DIV -> busy, HI and LO immediately 0; after release, no late commit occurs.
6. Back-to-back MULTU 0xFFFFFFFF*0xFFFFFFFF then MULT issued on the first non-busy cycle -> first result HI=0xFFFFFFFE, LO=0x00000001; second operation starts cleanly.
